fifo_stream_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It drives the FIFO's read enable, absorbs the FIFO's one-cycle registered read latency in a 3-entry output buffer, and presents the words on a valid/ready stream with burst framing (`o_last`). It sits directly downstream of the FIFO's read port and sustains one word per cycle with no combinational path from `i_ready` to `o_rd_en`.

---
 rtl/fifo_stream_reader_if.sv | 33 +++
 rtl/fifo_stream_reader.sv | 119 +++++++++++
 tb/tb_fifo_stream_reader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Read-port and stream signals of fifo_stream_reader.
// FIFO_RD_STATS_EN adds the delivered-word counter output.
interface fifo_stream_reader_if #(
  parameter int unsigned SIZE_DATA = 8
);
  logic                 o_rd_en;
  logic [SIZE_DATA-1:0] i_fifo_data;
  logic                 i_fifo_empty;
  logic                 i_flush;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_data;
  logic                 o_last;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]          o_word_cnt;
`endif

  modport master (
`ifdef FIFO_RD_STATS_EN
    output o_word_cnt,
`endif
    output o_rd_en, o_valid, o_data, o_last,
    input  i_fifo_data, i_fifo_empty, i_flush, i_ready
  );

  modport slave (
`ifdef FIFO_RD_STATS_EN
    input  o_word_cnt,
`endif
    input  o_rd_en, o_valid, o_data, o_last,
    output i_fifo_data, i_fifo_empty, i_flush, i_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: 3-entry skid buffer and burst-framed stream.
// FIFO_RD_STATS_EN enables the 16-bit delivered-word counter (o_word_cnt).
module fifo_stream_reader #(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fifo_stream_reader_if.master bus
);
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BURST_LEN - 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SIZE_DATA-1:0] mem [DEPTH];
  logic [1:0]           head;
  logic [1:0]           tail;
  logic [1:0]           cnt;
  logic                 inflight;
  logic [BCNT_W-1:0]    bcnt;
  logic                 rd_en_c;
  logic                 valid_c;
  logic                 last_c;
  logic                 run;
  logic                 flush_edge;
  logic                 push;
  logic                 pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Next state: FLUSH is held for as long as the flush request stays high
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.i_flush)  state_nxt = FLUSH;
      FLUSH:   if (!bus.i_flush) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs: read issue reserves a slot for the in-flight word, never looks at ready
  always_comb begin
    rd_en_c = 1'b0;
    valid_c = 1'b0;
    last_c  = 1'b0;
    if (state == RUN) begin
      rd_en_c = ~bus.i_fifo_empty & ((3'(cnt) + 3'(inflight)) < 3'd3);
      valid_c = (cnt != 2'd0);
      last_c  = valid_c & (bcnt == BCNT_MAX);
    end
  end

  assign run        = (state == RUN);
  assign flush_edge = run & bus.i_flush;
  assign push       = inflight & run;
  assign pop        = valid_c & bus.i_ready;

  // Buffer, pointers and burst position; returning data during FLUSH is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      head     <= 2'd0;
      tail     <= 2'd0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
      bcnt     <= '0;
    end else if (flush_edge) begin
      head     <= 2'd0;
      tail     <= 2'd0;
      cnt      <= 2'd0;
      bcnt     <= '0;
      inflight <= rd_en_c;
    end else begin
      inflight <= rd_en_c;
      if (push) begin
        mem[tail] <= bus.i_fifo_data;
        tail      <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
        bcnt <= last_c ? '0 : bcnt + BCNT_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.o_rd_en = rd_en_c;
  assign bus.o_valid = valid_c;
  assign bus.o_last  = last_c;
  assign bus.o_data  = mem[head];

`ifdef FIFO_RD_STATS_EN
  logic [15:0] word_cnt;

  // Survives flush; only reset clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 word_cnt <= 16'd0;
    else if (pop && !flush_edge)  word_cnt <= word_cnt + 16'd1;
  end

  assign bus.o_word_cnt = word_cnt;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, queue-based reference, table and directed sequences.
module tb_fifo_stream_reader;
  localparam int unsigned BL = 4;

  logic clk;
  logic rst_n;
  fifo_stream_reader_if #(.SIZE_DATA(8)) bus ();

  fifo_stream_reader #(.SIZE_DATA(8), .BURST_LEN(BL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       exp_rd;
    logic       exp_val;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  int         total;
  int         bad;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         hs_mod;
  int         hs_total;
  int         wc;
  logic       in_flush_state;
  logic       prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wc_check(input string name);
`ifdef FIFO_RD_STATS_EN
    chk(name, 32'(bus.o_word_cnt), 32'(16'(wc)));
`else
    if (name.len() == 0) $display("unnamed word count check");
`endif
  endtask

  // One cycle: drive at negedge, sample #1 later, update reference, cross posedge
  task automatic step(input logic rdy, input logic fl,
                      output logic s_rd, output logic s_val,
                      output logic [7:0] s_dat, output logic s_last);
    logic       rd_ok;
    logic [7:0] w;
    bus.i_ready      = rdy;
    bus.i_flush      = fl;
    bus.i_fifo_empty = (fifo_q.size() == 0);
    #1;
    s_rd  = bus.o_rd_en;
    s_val = bus.o_valid;
    s_dat = bus.o_data;
    s_last = bus.o_last;
    if (s_rd) chk("rd_en_when_empty", 32'(bus.i_fifo_empty), 32'd0);
    if (prev_stall) begin
      chk("stall_valid", 32'(s_val), 32'd1);
      chk("stall_data", 32'(s_dat), 32'(prev_data));
    end
    if (in_flush_state) begin
      chk("flush_state_rd_en", 32'(s_rd), 32'd0);
      chk("flush_state_valid", 32'(s_val), 32'd0);
    end else if (s_val) begin
      if (exp_q.size() == 0) chk("valid_without_word", 32'(s_val), 32'd0);
      else begin
        chk("data", 32'(s_dat), 32'(exp_q[0]));
        chk("last", 32'(s_last), 32'(hs_mod == int'(BL) - 1));
        if (rdy && !fl) begin
          void'(exp_q.pop_front());
          hs_mod = (hs_mod + 1) % int'(BL);
          hs_total++;
          wc++;
        end
      end
    end else begin
      chk("last_without_valid", 32'(s_last), 32'd0);
    end
    rd_ok = s_rd && (fifo_q.size() != 0);
    w = 8'($urandom);
    if (rd_ok) begin
      w = fifo_q.pop_front();
      if (!fl) exp_q.push_back(w);
    end
    if (fl) begin
      exp_q.delete();
      hs_mod = 0;
    end
    prev_stall     = s_val & ~rdy & ~fl & ~in_flush_state;
    prev_data      = s_dat;
    in_flush_state = fl;
    @(posedge clk);
    #1;
    bus.i_fifo_data = w;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    fifo_q.delete();
    bus.i_fifo_empty = 1'b1;
    bus.i_flush      = 1'b0;
    bus.i_ready      = 1'b0;
    #1;
    chk("rst_rd_en", 32'(bus.o_rd_en), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data",  32'(bus.o_data),  32'd0);
    chk("rst_last",  32'(bus.o_last),  32'd0);
    wc = 0;
    wc_check("rst_word_cnt");
    exp_q.delete();
    hs_mod = 0;
    in_flush_state = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget, input string name);
    logic a, b, d;
    logic [7:0] c;
    for (int i = 0; i < budget && (exp_q.size() + fifo_q.size()) > 0; i++) step(1'b1, 1'b0, a, b, c, d);
    chk(name, 32'(exp_q.size() + fifo_q.size()), 32'd0);
  endtask

  initial begin
    vec_t       tbl[11];
    logic       srd, sval, slast;
    logic [7:0] sdat;
    int         reads, n, last_at, start, wpush;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h12, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h13, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h14, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h15, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h16, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h17, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    total = 0; bad = 0; hs_total = 0; wc = 0; hs_mod = 0;
    in_flush_state = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
    rst_n = 1'b0;
    bus.i_fifo_data = 8'h00; bus.i_fifo_empty = 1'b1; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Streaming table
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].ready, 1'b0, srd, sval, sdat, slast);
      chk("tbl_rd_en", 32'(srd), 32'(tbl[i].exp_rd));
      chk("tbl_valid", 32'(sval), 32'(tbl[i].exp_val));
      if (tbl[i].exp_val) chk("tbl_data", 32'(sdat), 32'(tbl[i].exp_data));
      chk("tbl_last", 32'(slast), 32'(tbl[i].exp_last));
    end

    // Backpressure: three reads fill the buffer, then resume after the first pop
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h20 + i));
    reads = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, srd, sval, sdat, slast);
      reads += int'(srd);
    end
    chk("bp_reads", 32'(reads), 32'd3);
    chk("bp_head_valid", 32'(sval), 32'd1);
    chk("bp_head_data", 32'(sdat), 32'h20);
    start = hs_total;
    step(1'b1, 1'b0, srd, sval, sdat, slast);
    chk("bp_rd_at_first_pop", 32'(srd), 32'd0);
    step(1'b1, 1'b0, srd, sval, sdat, slast);
    chk("bp_rd_resume", 32'(srd), 32'd1);
    drain(30, "bp_drain");
    chk("bp_delivered", 32'(hs_total - start), 32'd6);

    // Flush with two buffered and one in flight
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h30 + i));
    repeat (3) step(1'b0, 1'b0, srd, sval, sdat, slast);
    step(1'b0, 1'b1, srd, sval, sdat, slast);
    step(1'b0, 1'b0, srd, sval, sdat, slast);
    chk("flush_cycle_valid", 32'(sval), 32'd0);
    chk("flush_cycle_rd_en", 32'(srd), 32'd0);
    n = 0; last_at = 0;
    for (int i = 0; i < 30 && last_at == 0; i++) begin
      step(1'b1, 1'b0, srd, sval, sdat, slast);
      if (i == 0) chk("flush_resume_rd", 32'(srd), 32'd1);
      if (sval) begin
        n++;
        if (n == 1) chk("flush_next_word", 32'(sdat), 32'h33);
        if (slast) last_at = n;
      end
    end
    chk("flush_last_pos", 32'(last_at), 32'd4);
    drain(30, "flush_drain");
    wc_check("word_cnt_after_flush");

    // Asynchronous reset after two handshakes of a burst
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h40 + i));
    start = hs_total;
    for (int i = 0; i < 10 && (hs_total - start) < 2; i++) step(1'b1, 1'b0, srd, sval, sdat, slast);
    chk("pre_reset_hs", 32'(hs_total - start), 32'd2);
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h50 + i));
    n = 0; last_at = 0;
    for (int i = 0; i < 30 && last_at == 0; i++) begin
      step(1'b1, 1'b0, srd, sval, sdat, slast);
      if (sval) begin
        n++;
        if (n == 1) chk("post_reset_first", 32'(sdat), 32'h50);
        if (slast) last_at = n;
      end
    end
    chk("post_reset_last_pos", 32'(last_at), 32'd4);
    drain(30, "reset_drain");

    // Random ready, 100 words
    start = hs_total; wpush = 0;
    for (int i = 0; i < 3000 && (hs_total - start) < 100; i++) begin
      if (wpush < 100 && $urandom_range(0, 9) < 7) begin
        fifo_q.push_back(8'($urandom));
        wpush++;
      end
      step(1'($urandom_range(0, 1)), 1'b0, srd, sval, sdat, slast);
    end
    chk("rand_delivered", 32'(hs_total - start), 32'd100);

    // Random ready, writes and flushes
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), srd, sval, sdat, slast);
    end
    drain(80, "rand_flush_drain");
    wc_check("word_cnt_random");

`ifdef FIFO_RD_STATS_EN
    do_reset();
    start = hs_total;
    for (int i = 0; i < 71000 && (hs_total - start) < 70000; i++) begin
      while (fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      step(1'b1, 1'b0, srd, sval, sdat, slast);
    end
    chk("stats_hs", 32'(hs_total - start), 32'd70000);
    chk("stats_word_cnt", 32'(bus.o_word_cnt), 32'd4464);
    step(1'b0, 1'b1, srd, sval, sdat, slast);
    step(1'b0, 1'b0, srd, sval, sdat, slast);
    chk("stats_after_flush", 32'(bus.o_word_cnt), 32'd4464);
    fifo_q.delete();
    drain(10, "stats_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
